// File: rtl/rob_rrat_pkg.sv
// Shared widths, entry field layout and helpers for the ROB/RRAT retirement back end.
package rob_rrat_pkg;

    localparam int unsigned NUM_PHYS_REGS  = 64;
    localparam int unsigned NUM_ARCH_REGS  = 35;
    localparam int unsigned ROB_DEPTH      = 64;
    localparam int unsigned ROB_ENTRY_BITS = 13;

    localparam int unsigned LOG_PHYS = $clog2(NUM_PHYS_REGS);
    localparam int unsigned LOG_ARCH = $clog2(NUM_ARCH_REGS);
    localparam int unsigned TAG_BITS = $clog2(ROB_DEPTH);

    localparam int unsigned PHYS_LSB     = 0;
    localparam int unsigned ARCH_LSB     = PHYS_LSB + LOG_PHYS;
    localparam int unsigned REGWRITE_BIT = ARCH_LSB + LOG_ARCH;

    typedef struct packed {
        logic                reg_write;
        logic [LOG_ARCH-1:0] arch;
        logic [LOG_PHYS-1:0] phys;
    } rob_entry_t;

    function automatic rob_entry_t unpack_entry(input logic [ROB_ENTRY_BITS-1:0] raw);
        rob_entry_t e;
        e.phys      = raw[PHYS_LSB +: LOG_PHYS];
        e.arch      = raw[ARCH_LSB +: LOG_ARCH];
        e.reg_write = raw[REGWRITE_BIT];
        return e;
    endfunction

    // Arch indices past the last real register are encodable but never map anywhere.
    function automatic logic arch_valid(input logic [LOG_ARCH-1:0] arch);
        return 32'(arch) < NUM_ARCH_REGS;
    endfunction

endpackage

// File: rtl/rob_rrat_unit_if.sv
// Allocate/complete/commit bundle of rob_rrat_unit; RRAT_FREED_REG_EN adds the freed-register pair.
interface rob_rrat_unit_if;
    import rob_rrat_pkg::*;

    logic                              Entry_valid_IN;
    logic [ROB_ENTRY_BITS-1:0]         Entry_IN;
    logic [TAG_BITS-1:0]               Alloc_tag_OUT;
    logic                              Full;
    logic                              Complete_valid_IN;
    logic [TAG_BITS-1:0]               Complete_tag_IN;
    logic                              ReadyCommit;
    logic                              RegUpdate;
    logic [LOG_ARCH-1:0]               Arch_reg;
    logic [LOG_PHYS-1:0]               Phys_reg;
    logic [NUM_ARCH_REGS*LOG_PHYS-1:0] regPtrs;
`ifdef RRAT_FREED_REG_EN
    logic                              Freed_valid_OUT;
    logic [LOG_PHYS-1:0]               Freed_reg_OUT;
`endif

    modport master (
`ifdef RRAT_FREED_REG_EN
        input  Freed_valid_OUT, Freed_reg_OUT,
`endif
        output Entry_valid_IN, Entry_IN, Complete_valid_IN, Complete_tag_IN,
        input  Alloc_tag_OUT, Full, ReadyCommit, RegUpdate, Arch_reg, Phys_reg, regPtrs
    );

    modport slave (
`ifdef RRAT_FREED_REG_EN
        output Freed_valid_OUT, Freed_reg_OUT,
`endif
        input  Entry_valid_IN, Entry_IN, Complete_valid_IN, Complete_tag_IN,
        output Alloc_tag_OUT, Full, ReadyCommit, RegUpdate, Arch_reg, Phys_reg, regPtrs
    );

endinterface

// File: rtl/rob_rrat_unit_rrat.sv
// Retirement register alias table: identity map on reset, one write port, flattened read-out.
module rrat
    import rob_rrat_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              we,
    input  logic [LOG_ARCH-1:0]               waddr,
    input  logic [LOG_PHYS-1:0]               wdata,
    output logic [NUM_ARCH_REGS*LOG_PHYS-1:0] ptrs
);

    logic [LOG_PHYS-1:0] map_q [NUM_ARCH_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                map_q[i] <= LOG_PHYS'(i);
            end
        end else if (we && arch_valid(waddr)) begin
            map_q[waddr] <= wdata;
        end
    end

    always_comb begin
        ptrs = '0;
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            ptrs[i*LOG_PHYS +: LOG_PHYS] = map_q[i];
        end
    end

endmodule

// File: rtl/rob_rrat_unit.sv
// Circular reorder buffer retiring one completed instruction per cycle into the RRAT.
// Define RRAT_FREED_REG_EN to expose the superseded physical register for the free list.
module rob_rrat_unit
    import rob_rrat_pkg::*;
(
    input logic            CLK,
    input logic            RESET,
    rob_rrat_unit_if.slave io
);

    rob_entry_t            entry_q [ROB_DEPTH];
    logic [ROB_DEPTH-1:0]  valid_q;
    logic [ROB_DEPTH-1:0]  done_q;
    logic [TAG_BITS-1:0]   head_q;
    logic [TAG_BITS-1:0]   tail_q;
    logic [TAG_BITS:0]     count_q;

    rob_entry_t head_e;
    logic       alloc;
    logic       commit;

    always_comb begin
        head_e = entry_q[head_q];
        commit = valid_q[head_q] && done_q[head_q];
        alloc  = io.Entry_valid_IN && !io.Full;
    end

    assign io.Full          = (count_q == (TAG_BITS+1)'(ROB_DEPTH));
    assign io.Alloc_tag_OUT = tail_q;
    assign io.ReadyCommit   = commit;
    assign io.RegUpdate     = commit && head_e.reg_write;
    assign io.Arch_reg      = head_e.arch;
    assign io.Phys_reg      = head_e.phys;

    // Payload needs no reset: valid_q gates every use of it.
    always_ff @(posedge CLK) begin
        if (alloc) begin
            entry_q[tail_q] <= unpack_entry(io.Entry_IN);
        end
    end

    // Alloc and commit never touch the same slot: that would need count == 0 and full at once.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (io.Complete_valid_IN && valid_q[io.Complete_tag_IN]) begin
                done_q[io.Complete_tag_IN] <= 1'b1;
            end
            if (commit) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + TAG_BITS'(1);
            end
            if (alloc) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                tail_q          <= tail_q + TAG_BITS'(1);
            end
            unique case ({alloc, commit})
                2'b10:   count_q <= count_q + (TAG_BITS+1)'(1);
                2'b01:   count_q <= count_q - (TAG_BITS+1)'(1);
                default: ;
            endcase
        end
    end

    rrat u_rrat (
        .clk   (CLK),
        .rst   (RESET),
        .we    (io.RegUpdate),
        .waddr (head_e.arch),
        .wdata (head_e.phys),
        .ptrs  (io.regPtrs)
    );

`ifdef RRAT_FREED_REG_EN
    always_comb begin
        io.Freed_reg_OUT = '0;
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            if (head_e.arch == LOG_ARCH'(i)) begin
                io.Freed_reg_OUT = io.regPtrs[i*LOG_PHYS +: LOG_PHYS];
            end
        end
    end
    assign io.Freed_valid_OUT = io.RegUpdate;
`endif

endmodule

// File: tb/tb_rob_rrat_unit.sv
// Bench for rob_rrat_unit: directed vector table plus a commit-order scoreboard and RRAT model.
module tb_rob_rrat_unit;
    import rob_rrat_pkg::*;

    typedef struct {
        bit rw;
        int arch;
        int phys;
    } exp_t;

    typedef struct {
        bit          ev;
        logic [12:0] ent;
        bit          cv;
        logic [5:0]  ctag;
        bit          ready;
        int          arch;
        int          phys;
        bit          upd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rob_rrat_unit_if bus ();

    rob_rrat_unit dut (
        .CLK   (clk),
        .RESET (rst),
        .io    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model
    bit   m_valid [64];
    bit   m_done  [64];
    int   m_head, m_tail, m_count;
    int   m_map   [NUM_ARCH_REGS];
    exp_t sb [$];

    bit          cur_ev, cur_cv, m_commit, have_ce;
    logic [12:0] cur_ent;
    logic [5:0]  cur_ctag;
    exp_t        ce;
    vec_t        tbl [15];

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [12:0] mk(input bit rw, input int arch, input int phys);
        return {rw, 6'(arch), 6'(phys)};
    endfunction

    function automatic logic [NUM_ARCH_REGS*LOG_PHYS-1:0] map_vec();
        logic [NUM_ARCH_REGS*LOG_PHYS-1:0] v;
        for (int i = 0; i < NUM_ARCH_REGS; i++) v[i*LOG_PHYS +: LOG_PHYS] = 6'(m_map[i]);
        return v;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0;
            m_done[i]  = 0;
        end
        for (int i = 0; i < NUM_ARCH_REGS; i++) m_map[i] = i;
        m_head = 0; m_tail = 0; m_count = 0;
        sb.delete();
    endtask

    // Called at posedge+1: apply inputs and check the combinational view of pre-edge state.
    task automatic drive(input bit ev, input logic [12:0] ent, input bit cv, input logic [5:0] ctag);
        bus.Entry_valid_IN = ev;  bus.Entry_IN = ent;
        bus.Complete_valid_IN = cv; bus.Complete_tag_IN = ctag;
        cur_ev = ev; cur_ent = ent; cur_cv = cv; cur_ctag = ctag;
        #2;
        m_commit = m_valid[m_head] && m_done[m_head];
        have_ce  = 0;
        chk("full", bus.Full, m_count == 64);
        chk("alloc_tag", bus.Alloc_tag_OUT, m_tail);
        chk("ready", bus.ReadyCommit, m_commit);
        if (m_commit) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sb_underflow @%0t: commit expected with empty scoreboard", $time);
            end else begin
                ce = sb.pop_front();
                have_ce = 1;
                chk("arch_reg", bus.Arch_reg, ce.arch);
                chk("phys_reg", bus.Phys_reg, ce.phys);
                chk("reg_update", bus.RegUpdate, ce.rw);
            end
        end
    endtask

    task automatic advance();
        bit accept;
        accept = cur_ev && (m_count != 64);
        if (cur_cv && m_valid[cur_ctag]) m_done[cur_ctag] = 1;
        if (m_commit) begin
            m_valid[m_head] = 0;
            m_head = (m_head + 1) % 64;
            m_count--;
            if (have_ce && ce.rw && ce.arch < NUM_ARCH_REGS) m_map[ce.arch] = ce.phys;
        end
        if (accept) begin
            m_valid[m_tail] = 1;
            m_done[m_tail]  = 0;
            sb.push_back('{rw: cur_ent[12], arch: int'(cur_ent[11:6]), phys: int'(cur_ent[5:0])});
            m_tail = (m_tail + 1) % 64;
            m_count++;
        end
        @(posedge clk);
        #1;
        chk("regptrs", bus.regPtrs, map_vec());
    endtask

    task automatic drain();
        int ct   = m_head;
        int left = m_count;
        for (int k = 0; k < 300 && m_count > 0; k++) begin
            drive(0, '0, left > 0, 6'(ct));
            if (left > 0) begin
                ct = (ct + 1) % 64;
                left--;
            end
            advance();
        end
        if (m_count != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d entries left, required 0", m_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Entry_valid_IN = 0; bus.Entry_IN = '0;
        bus.Complete_valid_IN = 0; bus.Complete_tag_IN = '0;
        reset_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_slice5", bus.regPtrs[5*LOG_PHYS +: LOG_PHYS], 5);
        chk("rst_full", bus.Full, 0);
        chk("rst_ready", bus.ReadyCommit, 0);
        chk("rst_alloc_tag", bus.Alloc_tag_OUT, 0);
        @(posedge clk); #1;

        // ev, entry, cv, ctag | ready, arch, phys, upd
        tbl[0]  = '{1, mk(1, 3, 40), 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 13'd0,        1, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 13'd0,        0, 0, 1, 3, 40, 1};
        tbl[3]  = '{1, mk(1, 7, 11), 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, mk(1, 8, 12), 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 13'd0,        1, 2, 0, 0, 0, 0};
        tbl[6]  = '{0, 13'd0,        0, 0, 0, 0, 0, 0};
        tbl[7]  = '{0, 13'd0,        1, 1, 0, 0, 0, 0};
        tbl[8]  = '{0, 13'd0,        0, 0, 1, 7, 11, 1};
        tbl[9]  = '{0, 13'd0,        0, 0, 1, 8, 12, 1};
        tbl[10] = '{0, 13'd0,        0, 0, 0, 0, 0, 0};
        tbl[11] = '{1, mk(0, 9, 50), 0, 0, 0, 0, 0, 0};
        tbl[12] = '{0, 13'd0,        1, 3, 0, 0, 0, 0};
        tbl[13] = '{0, 13'd0,        0, 0, 1, 9, 50, 0};
        tbl[14] = '{0, 13'd0,        0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].ev, tbl[i].ent, tbl[i].cv, tbl[i].ctag);
            chk("tbl_ready", bus.ReadyCommit, tbl[i].ready);
            if (tbl[i].ready) begin
                chk("tbl_arch", bus.Arch_reg, tbl[i].arch);
                chk("tbl_phys", bus.Phys_reg, tbl[i].phys);
                chk("tbl_upd", bus.RegUpdate, tbl[i].upd);
            end
            advance();
        end
        chk("map3_is_40", bus.regPtrs[3*LOG_PHYS +: LOG_PHYS], 40);
        chk("map7_is_11", bus.regPtrs[7*LOG_PHYS +: LOG_PHYS], 11);
        chk("map8_is_12", bus.regPtrs[8*LOG_PHYS +: LOG_PHYS], 12);
        chk("map9_kept", bus.regPtrs[9*LOG_PHYS +: LOG_PHYS], 9);

        // Fill to capacity, then commit while full with an allocation pending.
        for (int i = 0; i < 64; i++) begin
            drive(1, mk(1, i % 35, i), 0, 0);
            advance();
        end
        drive(1, mk(1, 1, 60), 0, 0);
        chk("full_after_64", bus.Full, 1);
        advance();
        drive(1, mk(1, 1, 60), 1, 6'(m_head));
        advance();
        drive(1, mk(1, 2, 61), 0, 0);
        chk("full_on_commit", bus.Full, 1);
        chk("ready_on_full", bus.ReadyCommit, 1);
        advance();
        drive(1, mk(1, 2, 61), 0, 0);
        chk("not_full_next", bus.Full, 0);
        advance();
        drain();

        // Streaming alloc/complete/commit with tag wrap and out-of-range arch indices.
        begin
            int last = -1;
            int tg;
            for (int i = 0; i < 100; i++) begin
                drive(1, mk($urandom_range(1), $urandom_range(40), $urandom_range(63)),
                      last >= 0, 6'(last < 0 ? 0 : last));
                tg = m_tail;
                advance();
                last = tg;
            end
            drive(0, '0, 1, 6'(last));
            advance();
        end
        drain();

        // Asynchronous reset while an entry is ready to retire.
        drive(1, mk(1, 4, 33), 0, 0);
        advance();
        drive(1, mk(1, 5, 34), 1, 6'(m_head));
        advance();
        drive(0, '0, 0, 0);
        rst = 1'b1;
        #1;
        reset_model();
        chk("arst_ready", bus.ReadyCommit, 0);
        chk("arst_full", bus.Full, 0);
        chk("arst_alloc_tag", bus.Alloc_tag_OUT, 0);
        chk("arst_identity", bus.regPtrs, map_vec());
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1, mk(1, 6, 21), 0, 0);
        advance();
        drive(0, '0, 1, 0);
        advance();
        drain();
        chk("post_reset_map6", bus.regPtrs[6*LOG_PHYS +: LOG_PHYS], 21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
